axil_stream_reader: RTL and testbench

AXIL_STREAM_READER -- requirements
Module: axil_stream_reader

---
 rtl/axil_stream_reader_pkg.sv | 35 +++
 rtl/axil_stream_reader_sync_fifo.sv | 69 ++++++
 rtl/axil_stream_reader.sv | 171 +++++++++++++++++
 tb/tb_axil_stream_reader.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_stream_reader_pkg.sv
// ============================================================================
// Module      : axil_stream_reader_pkg
// Description : Shared constants, state encoding and log2 helper for the
//               AXI-Lite to AXI-Stream reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axil_stream_reader_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axil_stream_reader_sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with full/empty flags and an occupancy count;
//               simultaneous push and pop on a full FIFO is allowed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo
    import axil_stream_reader_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int AW   = log2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_wr_en;
    logic             w_rd_en;

    assign full     = (r_count == CW'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];

    // The head slot is read combinationally, so a full FIFO can accept a
    // write into the slot being popped in the same cycle.
    assign w_wr_en = push && (!full || pop);
    assign w_rd_en = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_wr_en) - CW'(w_rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/axil_stream_reader.sv
// ============================================================================
// Module      : axil_stream_reader
// Description : Reads cmd_len+1 consecutive words over AXI-Lite and streams
//               them out on AXI-Stream with tlast on the final beat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_stream_reader
    import axil_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,

    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,

    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CW = log2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic                  r_arvalid;
    logic                  r_rready;
    logic                  r_cmd_ready;
    logic                  r_done;
    logic                  r_err;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_beat;
    logic [LEN_WIDTH-1:0]  r_ar_left;
    logic [CW-1:0]         r_reserved;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [CW-1:0]         w_count;
    logic [CW-1:0]         w_free;
    logic                  w_issue;
    logic                  w_accept;
    logic                  w_last_hs;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (m_axil_rdata),
        .pop       (w_pop),
        .pop_data  (m_axis_tdata),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    assign m_axil_araddr  = r_araddr;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = r_arvalid;
    assign m_axil_rready  = r_rready;
    assign cmd_ready      = r_cmd_ready;
    assign busy           = (r_state == ST_RUN);
    assign done           = r_done;
    assign err            = r_err;

    assign m_axis_tvalid  = !w_empty;
    assign m_axis_tlast   = !w_empty && (r_beat == r_len);

    assign w_accept  = cmd_valid && r_cmd_ready;
    assign w_push    = m_axil_rvalid && r_rready;
    assign w_pop     = m_axis_tvalid && m_axis_tready;
    assign w_last_hs = w_pop && m_axis_tlast;
    assign w_free    = w_full ? '0 : CW'(FIFO_DEPTH) - w_count;

    // r_reserved counts every AR launched whose R beat has not yet landed, so a
    // new AR is only launched while a FIFO slot is still unclaimed.
    assign w_issue = (r_state == ST_RUN) && (r_ar_left != '0) &&
                     (!r_arvalid || m_axil_arready) && (w_free > r_reserved);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_len       <= '0;
            r_beat      <= '0;
            r_ar_left   <= '0;
            r_reserved  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        r_state     <= ST_RUN;
                        r_cmd_ready <= 1'b0;
                        r_araddr    <= cmd_addr & ALIGN_MASK;
                        r_arvalid   <= 1'b1;
                        r_rready    <= 1'b1;
                        r_len       <= cmd_len;
                        r_beat      <= '0;
                        r_ar_left   <= cmd_len;
                        r_reserved  <= CW'(1);
                        r_err       <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_issue) begin
                        r_arvalid <= 1'b1;
                        r_araddr  <= r_araddr + ADDR_WIDTH'(STRB_WIDTH);
                        r_ar_left <= r_ar_left - LEN_WIDTH'(1);
                    end else if (m_axil_arready) begin
                        r_arvalid <= 1'b0;
                    end
                    r_reserved <= r_reserved + CW'(w_issue) - CW'(w_push);
                    if (w_push && (m_axil_rresp != RESP_OKAY)) begin
                        r_err <= 1'b1;
                    end
                    if (w_pop) begin
                        r_beat <= r_beat + LEN_WIDTH'(1);
                    end
                    if (w_last_hs) begin
                        r_state     <= ST_IDLE;
                        r_done      <= 1'b1;
                        r_cmd_ready <= 1'b1;
                        r_rready    <= 1'b0;
                        r_arvalid   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axil_stream_reader.sv
// ============================================================================
// Module      : tb_axil_stream_reader
// Description : Scoreboard bench for axil_stream_reader with a one-cycle
//               latency AXI-Lite slave model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axil_stream_reader;

    localparam int DW = 32;
    localparam int AW = 9;
    localparam int LW = 8;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready = 1'b1;
    logic [DW-1:0] rdata = '0;
    logic [1:0]    rresp = '0;
    logic          rvalid = 1'b0;
    logic          rready;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready = 1'b1;
    logic          tlast;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    axil_stream_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .STRB_WIDTH (DW / 8),
        .LEN_WIDTH  (LW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .m_axil_araddr  (araddr),
        .m_axil_arprot  (arprot),
        .m_axil_arvalid (arvalid),
        .m_axil_arready (arready),
        .m_axil_rdata   (rdata),
        .m_axil_rresp   (rresp),
        .m_axil_rvalid  (rvalid),
        .m_axil_rready  (rready),
        .m_axis_tdata   (tdata),
        .m_axis_tvalid  (tvalid),
        .m_axis_tready  (tready),
        .m_axis_tlast   (tlast),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } rbeat_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            ar_cnt = 0;
    logic [AW-1:0] exp_ar[$];
    beat_t         exp_beat[$];
    int            ar_cyc[$];
    int            beat_cyc[$];
    rbeat_t        rq[$];
    logic          ar_ready_en = 1'b1;
    logic          err_en = 1'b0;
    logic [AW-1:0] err_addr = '0;
    logic          prev_last = 1'b0;
    logic          s_ar;
    logic          s_r;
    logic [AW-1:0] s_addr;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
        return 32'hA500_0000 | {23'b0, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // AXI-Lite slave: R beat presented the cycle after the AR handshake,
    // held until rready.
    initial begin
        rbeat_t f;
        forever begin
            @(negedge clk);
            s_ar   = arvalid && arready;
            s_r    = rvalid && rready;
            s_addr = araddr;
            @(posedge clk);
            #1;
            if (rst) begin
                rq.delete();
                rvalid = 1'b0;
            end else begin
                if (s_ar) begin
                    rq.push_back('{data: word_at(s_addr),
                                   resp: (err_en && s_addr == err_addr) ? 2'b10 : 2'b00});
                end
                if (s_r && rq.size() > 0) void'(rq.pop_front());
                if (rq.size() > 0) begin
                    f      = rq[0];
                    rvalid = 1'b1;
                    rdata  = f.data;
                    rresp  = f.resp;
                end else begin
                    rvalid = 1'b0;
                end
            end
            arready = ar_ready_en;
        end
    end

    always @(negedge clk) begin
        if (!rst && arvalid && arready) begin
            ar_cnt++;
            ar_cyc.push_back(cyc);
            if (exp_ar.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ar_unexpected: got %0h, expected no AR", araddr);
            end else begin
                check("ar_addr", {23'b0, araddr}, {23'b0, exp_ar.pop_front()});
            end
            check("arprot", {29'b0, arprot}, 32'd0);
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (!rst && tvalid && tready) begin
            beat_cyc.push_back(cyc);
            if (exp_beat.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat_unexpected: got %0h, expected no beat", tdata);
            end else begin
                e = exp_beat.pop_front();
                check("tdata", tdata, e.data);
                check("tlast", {31'b0, tlast}, {31'b0, e.last});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && (prev_last || done)) check("done_pulse", {31'b0, done}, {31'b0, prev_last});
        prev_last = !rst && tvalid && tready && tlast;
    end

    task automatic issue_cmd(input logic [AW-1:0] addr, input logic [LW-1:0] len, output int acc_cyc);
        logic [AW-1:0] a;
        a = addr & 9'h1FC;
        for (int i = 0; i <= int'(len); i++) begin
            exp_ar.push_back(a);
            exp_beat.push_back('{data: word_at(a), last: (i == int'(len))});
            a = a + 9'd4;
        end
        @(posedge clk);
        #1;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_valid = 1'b1;
        acc_cyc   = -1;
        for (int t = 0; t < 100 && acc_cyc < 0; t++) begin
            @(negedge clk);
            if (cmd_ready) acc_cyc = cyc;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (acc_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept: got timeout, expected cmd_ready");
        end
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < 300 && !seen; t++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_wait: got timeout, expected done");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", {31'b0, cmd_ready}, 0);
        check("rst_busy",      {31'b0, busy},      0);
        check("rst_arvalid",   {31'b0, arvalid},   0);
        check("rst_rready",    {31'b0, rready},    0);
        check("rst_tvalid",    {31'b0, tvalid},    0);
        check("rst_tlast",     {31'b0, tlast},     0);
        check("rst_done",      {31'b0, done},      0);
        check("rst_err",       {31'b0, err},       0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("cmd_ready_after_rst", {31'b0, cmd_ready}, 1);

        // Basic 4-beat burst at full rate.
        ar_cyc.delete();
        beat_cyc.delete();
        issue_cmd(9'h010, 8'd3, acc);
        wait_done();
        check("busy_after_done", {31'b0, busy}, 0);
        check("t1_ar_count", ar_cyc.size(), 4);
        check("t1_beat_count", beat_cyc.size(), 4);
        if (ar_cyc.size() == 4 && beat_cyc.size() == 4) begin
            check("t1_first_ar_latency", ar_cyc[0] - acc, 1);
            check("t1_first_beat_latency", beat_cyc[0] - acc, 3);
            check("t1_back_to_back", beat_cyc[3] - beat_cyc[0], 3);
        end

        // Address wrap at the top of the 9-bit space.
        issue_cmd(9'h1F8, 8'd3, acc);
        wait_done();

        // Stalled stream: AR issue bounded by FIFO depth.
        @(posedge clk);
        #1;
        tready = 1'b0;
        ar_cnt = 0;
        issue_cmd(9'h000, 8'd7, acc);
        repeat (20) @(posedge clk);
        #1;
        check("stall_ar_count", ar_cnt, FD);
        tready = 1'b1;
        wait_done();

        // Error response on beat 1 of 3.
        err_en   = 1'b1;
        err_addr = 9'h104;
        issue_cmd(9'h100, 8'd2, acc);
        wait_done();
        repeat (3) @(negedge clk);
        check("err_sticky", {31'b0, err}, 1);
        err_en = 1'b0;
        issue_cmd(9'h020, 8'd0, acc);
        @(negedge clk);
        check("err_cleared", {31'b0, err}, 0);
        wait_done();

        // Reset in the middle of a 6-beat command.
        beat_cyc.delete();
        issue_cmd(9'h040, 8'd5, acc);
        for (int t = 0; t < 200 && beat_cyc.size() < 2; t++) begin
            @(posedge clk);
            #2;
        end
        rst         = 1'b1;
        tready      = 1'b0;
        ar_ready_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy",    {31'b0, busy},    0);
        check("midrst_tvalid",  {31'b0, tvalid},  0);
        check("midrst_arvalid", {31'b0, arvalid}, 0);
        check("midrst_rready",  {31'b0, rready},  0);
        exp_ar.delete();
        exp_beat.delete();
        @(posedge clk);
        #1;
        rst         = 1'b0;
        tready      = 1'b1;
        ar_ready_en = 1'b1;
        repeat (2) @(posedge clk);
        issue_cmd(9'h080, 8'd1, acc);
        wait_done();

        // Unaligned address, single beat.
        beat_cyc.delete();
        issue_cmd(9'h007, 8'd0, acc);
        wait_done();
        check("single_beat_count", beat_cyc.size(), 1);

        repeat (5) @(negedge clk);
        check("ar_queue_drained", exp_ar.size(), 0);
        check("beat_queue_drained", exp_beat.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
